// File: rtl/pb_intc_pkg.sv
// Shared definitions for the Picoblaze vectored interrupt controller:
// FSM encodings, the "no vector" code, source-count limits and a priority helper.
package pb_intc_pkg;

   localparam int NUM_SRC_MIN = 1;
   localparam int NUM_SRC_MAX = 32;
   localparam int VEC_W       = 8;

   localparam logic [VEC_W-1:0] NO_VECTOR = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Fixed priority: the lowest set index wins; NO_VECTOR when nothing is set.
   function automatic logic [VEC_W-1:0] f_lowest(input logic [NUM_SRC_MAX-1:0] v);
      logic [VEC_W-1:0] idx;
      idx = NO_VECTOR;
      for (int i = NUM_SRC_MAX - 1; i >= 0; i--) begin
         if (v[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/pb_vectored_intc_if.sv
// Register-file / Picoblaze side signals of the interrupt controller.
// master drives sources, mask, mode, clear and ack; slave is the controller.
interface pb_vectored_intc_if
   import pb_intc_pkg::*;
#(
   parameter int NUM_SRC = 8
) ();

   logic [NUM_SRC-1:0] int_src;
   logic [NUM_SRC-1:0] int_mask;
   logic [NUM_SRC-1:0] int_mode;
   logic [NUM_SRC-1:0] int_clear;
   logic               int_ack_i;
   logic [NUM_SRC-1:0] interrupts;
   logic [VEC_W-1:0]   int_vector;
   logic               int_o;

   modport master (
      output int_src, int_mask, int_mode, int_clear, int_ack_i,
      input  interrupts, int_vector, int_o
   );

   modport slave (
      input  int_src, int_mask, int_mode, int_clear, int_ack_i,
      output interrupts, int_vector, int_o
   );

endinterface

// File: rtl/pb_intc_sync.sv
// Single-bit synchroniser followed by a registered rising-edge detector.
// o_level is the delayed synchronised level, aligned with o_edge.
module pb_intc_sync
   import pb_intc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_src,
   output logic o_edge,
   output logic o_level
);

   localparam logic [1:0] LP_SS = 2'(SYNC_STAGES);

   logic       w_sync_q;
   logic       r_sync_d1;
   logic       r_edge;
   logic       r_arm;
   logic [1:0] r_cnt;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_sync_q = i_src;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_sync;
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_sync <= '0;
            end else begin
               r_sync[0] <= i_src;
               for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            end
         end
         assign w_sync_q = r_sync[SYNC_STAGES-1];
      end
   endgenerate

   // Edges are armed only after a post-reset low has been seen, so a source
   // held high through reset never looks like a fresh rising edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync_d1 <= 1'b0;
         r_edge    <= 1'b0;
         r_arm     <= 1'b0;
         r_cnt     <= 2'd0;
      end else begin
         r_sync_d1 <= w_sync_q;
         r_edge    <= w_sync_q & ~r_sync_d1 & r_arm;
         if (r_cnt != LP_SS) r_cnt <= r_cnt + 2'd1;
         else if (!w_sync_q) r_arm <= 1'b1;
      end
   end

   assign o_edge  = r_edge;
   assign o_level = r_sync_d1;

endmodule

// File: rtl/pb_vectored_intc.sv
// Vectored interrupt controller for a Picoblaze: per-source pending capture,
// fixed lowest-index priority and an IDLE/ASSERT/SERVICE request FSM.
module pb_vectored_intc
   import pb_intc_pkg::*;
#(
   parameter int NUM_SRC     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   pb_vectored_intc_if.slave   bus
);

   generate
      if (NUM_SRC < NUM_SRC_MIN || NUM_SRC > NUM_SRC_MAX) begin : g_bad_num_src
         $error("pb_vectored_intc: NUM_SRC out of range");
      end
      if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
         $error("pb_vectored_intc: SYNC_STAGES out of range");
      end
   endgenerate

   logic [NUM_SRC-1:0]     w_edge;
   logic [NUM_SRC-1:0]     w_level;
   logic [NUM_SRC-1:0]     r_pending;
   logic [NUM_SRC-1:0]     w_pending_next;
   logic [NUM_SRC-1:0]     w_active;
   logic [NUM_SRC_MAX-1:0] w_active32;
   logic [VEC_W-1:0]       w_winner;
   logic                   w_any;
   logic                   w_srv_live;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   r_int_o;
   logic                   w_int_o_next;
   logic [VEC_W-1:0]       r_vector;
   logic [VEC_W-1:0]       w_vector_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         pb_intc_sync #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_sync (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .i_src   (bus.int_src[gi]),
            .o_edge  (w_edge[gi]),
            .o_level (w_level[gi])
         );
      end
   endgenerate

   // Edge bits: a new edge beats a simultaneous clear. Level bits track the level.
   always_comb begin
      w_pending_next = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.int_mode[i]) w_pending_next[i] = w_edge[i] | (r_pending[i] & ~bus.int_clear[i]);
         else                 w_pending_next[i] = w_level[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_pending <= '0;
      else       r_pending <= w_pending_next;
   end

   assign w_active   = r_pending & bus.int_mask;
   assign w_active32 = NUM_SRC_MAX'(w_active);
   assign w_winner   = f_lowest(w_active32);
   assign w_any      = |w_active;
   assign w_srv_live = w_active32[r_vector[4:0]];

   always_comb begin
      w_state_next  = r_state;
      w_int_o_next  = 1'b0;
      w_vector_next = w_winner;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next = ST_ASSERT;
               w_int_o_next = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (!w_any)              w_state_next = ST_IDLE;
            else if (bus.int_ack_i)  w_state_next = ST_SERVICE;
            else                     w_int_o_next = 1'b1;
         end
         ST_SERVICE: begin
            w_vector_next = r_vector;
            if (!w_srv_live) begin
               w_state_next  = ST_IDLE;
               w_vector_next = w_winner;
            end
         end
         default: begin
            w_state_next  = ST_IDLE;
            w_vector_next = NO_VECTOR;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_int_o  <= 1'b0;
         r_vector <= NO_VECTOR;
      end else begin
         r_state  <= w_state_next;
         r_int_o  <= w_int_o_next;
         r_vector <= w_vector_next;
      end
   end

   assign bus.interrupts = w_active;
   assign bus.int_vector = r_vector;
   assign bus.int_o      = r_int_o;

endmodule

// File: tb/tb_pb_vectored_intc.sv
// Directed bench for pb_vectored_intc: an 8-source instance for the main
// features and a 32-source instance for reset behaviour on source 31.
module tb_pb_vectored_intc;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_i = ~clk_i;

   pb_vectored_intc_if #(.NUM_SRC(8))  bus8 ();
   pb_vectored_intc_if #(.NUM_SRC(32)) bus32 ();

   pb_vectored_intc #(.NUM_SRC(8), .SYNC_STAGES(2)) u_dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus8.slave)
   );

   pb_vectored_intc #(.NUM_SRC(32), .SYNC_STAGES(2)) u_dut32 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus32.slave)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic zero_inputs();
      bus8.int_src = '0;  bus8.int_mask = '0;  bus8.int_mode = '0;
      bus8.int_clear = '0; bus8.int_ack_i = 1'b0;
      bus32.int_src = '0; bus32.int_mask = '0; bus32.int_mode = '0;
      bus32.int_clear = '0; bus32.int_ack_i = 1'b0;
   endtask

   task automatic apply_reset();
      zero_inputs();
      rst_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
      tick(4);
   endtask

   task automatic test_reset();
      zero_inputs();
      bus8.int_mask = 8'hFF;
      rst_i = 1'b1;
      tick(2);
      checks++; if (bus8.int_o !== 1'b0) begin errors++; $display("FAIL reset_int_o: got %b want 0", bus8.int_o); end
      checks++; if (bus8.int_vector !== 8'hFF) begin errors++; $display("FAIL reset_vector: got %h want ff", bus8.int_vector); end
      checks++; if (bus8.interrupts !== 8'h00) begin errors++; $display("FAIL reset_pending: got %h want 00", bus8.interrupts); end
      rst_i = 1'b0;
      tick(4);
      $display("test_reset done");
   endtask

   task automatic test_latency();
      apply_reset();
      bus8.int_mask = 8'h03; bus8.int_mode = 8'h01;
      bus8.int_src = 8'h01;
      tick(1);                       // edge k samples the pulse
      bus8.int_src = 8'h00;
      tick(2);                       // k+2
      checks++; if (bus8.interrupts !== 8'h00) begin errors++; $display("FAIL lat_pend_early: got %h want 00", bus8.interrupts); end
      tick(1);                       // k+3
      checks++; if (bus8.interrupts !== 8'h01) begin errors++; $display("FAIL lat_pend_k3: got %h want 01", bus8.interrupts); end
      checks++; if (bus8.int_o !== 1'b0) begin errors++; $display("FAIL lat_into_k3: got %b want 0", bus8.int_o); end
      tick(1);                       // k+4
      checks++; if (bus8.int_o !== 1'b1) begin errors++; $display("FAIL lat_into_k4: got %b want 1", bus8.int_o); end
      checks++; if (bus8.int_vector !== 8'h00) begin errors++; $display("FAIL lat_vector: got %h want 00", bus8.int_vector); end
      tick(3);
      checks++; if (bus8.int_o !== 1'b1) begin errors++; $display("FAIL lat_hold: got %b want 1", bus8.int_o); end
      $display("test_latency done");
   endtask

   task automatic test_priority_service();
      apply_reset();
      bus8.int_mask = 8'hFF; bus8.int_mode = 8'hFF;
      bus8.int_src = 8'h06;
      tick(1);
      bus8.int_src = 8'h00;
      tick(3);
      checks++; if (bus8.interrupts !== 8'h06) begin errors++; $display("FAIL prio_pend: got %h want 06", bus8.interrupts); end
      tick(1);
      checks++; if (bus8.int_vector !== 8'h01) begin errors++; $display("FAIL prio_vector: got %h want 01", bus8.int_vector); end
      bus8.int_ack_i = 1'b1;
      tick(1);
      bus8.int_ack_i = 1'b0;
      checks++; if (bus8.int_o !== 1'b0) begin errors++; $display("FAIL ack_into: got %b want 0", bus8.int_o); end
      checks++; if (bus8.int_vector !== 8'h01) begin errors++; $display("FAIL ack_vector: got %h want 01", bus8.int_vector); end
      tick(2);
      checks++; if (bus8.int_vector !== 8'h01 || bus8.int_o !== 1'b0) begin errors++; $display("FAIL service_hold: got vec %h int_o %b want 01/0", bus8.int_vector, bus8.int_o); end
      bus8.int_clear = 8'h02;
      tick(1);
      bus8.int_clear = 8'h00;
      checks++; if (bus8.interrupts !== 8'h04) begin errors++; $display("FAIL clear_pend: got %h want 04", bus8.interrupts); end
      tick(1);
      checks++; if (bus8.int_o !== 1'b0) begin errors++; $display("FAIL gap_cycle: got %b want 0", bus8.int_o); end
      tick(1);
      checks++; if (bus8.int_o !== 1'b1) begin errors++; $display("FAIL reassert_into: got %b want 1", bus8.int_o); end
      checks++; if (bus8.int_vector !== 8'h02) begin errors++; $display("FAIL reassert_vector: got %h want 02", bus8.int_vector); end
      $display("test_priority_service done");
   endtask

   task automatic test_set_wins();
      apply_reset();
      bus8.int_mask = 8'h08; bus8.int_mode = 8'h08;
      bus8.int_src = 8'h08;
      tick(1);
      bus8.int_src = 8'h00;
      tick(3);
      checks++; if (bus8.interrupts !== 8'h08) begin errors++; $display("FAIL setwin_first: got %h want 08", bus8.interrupts); end
      tick(2);
      bus8.int_src = 8'h08;
      tick(1);
      bus8.int_src = 8'h00;
      tick(2);
      bus8.int_clear = 8'h08;        // lands with the second edge
      tick(1);
      bus8.int_clear = 8'h00;
      checks++; if (bus8.interrupts !== 8'h08) begin errors++; $display("FAIL setwin_same_cycle: got %h want 08", bus8.interrupts); end
      tick(1);
      bus8.int_clear = 8'h08;
      tick(1);
      bus8.int_clear = 8'h00;
      checks++; if (bus8.interrupts !== 8'h00) begin errors++; $display("FAIL setwin_lone_clear: got %h want 00", bus8.interrupts); end
      $display("test_set_wins done");
   endtask

   task automatic test_level();
      apply_reset();
      bus8.int_mask = 8'h04; bus8.int_mode = 8'h00;
      bus8.int_src = 8'h04;
      tick(5);
      checks++; if (bus8.interrupts !== 8'h04) begin errors++; $display("FAIL level_set: got %h want 04", bus8.interrupts); end
      bus8.int_clear = 8'h04;
      tick(1);
      bus8.int_clear = 8'h00;
      tick(1);
      checks++; if (bus8.interrupts !== 8'h04) begin errors++; $display("FAIL level_clear_ignored: got %h want 04", bus8.interrupts); end
      bus8.int_src = 8'h00;
      tick(3);                       // k+2
      checks++; if (bus8.interrupts !== 8'h04) begin errors++; $display("FAIL level_release_k2: got %h want 04", bus8.interrupts); end
      tick(1);                       // k+3
      checks++; if (bus8.interrupts !== 8'h00) begin errors++; $display("FAIL level_release_k3: got %h want 00", bus8.interrupts); end
      $display("test_level done");
   endtask

   task automatic test_mask_drop();
      apply_reset();
      bus8.int_mask = 8'h01; bus8.int_mode = 8'h01;
      bus8.int_src = 8'h01;
      tick(1);
      bus8.int_src = 8'h00;
      tick(4);
      checks++; if (bus8.int_o !== 1'b1) begin errors++; $display("FAIL drop_pre_into: got %b want 1", bus8.int_o); end
      bus8.int_mask = 8'h00;
      tick(1);
      checks++; if (bus8.int_o !== 1'b0 || bus8.int_vector !== 8'hFF) begin errors++; $display("FAIL drop_idle: got int_o %b vec %h want 0/ff", bus8.int_o, bus8.int_vector); end
      checks++; if (bus8.interrupts !== 8'h00) begin errors++; $display("FAIL drop_interrupts: got %h want 00", bus8.interrupts); end
      bus8.int_ack_i = 1'b1;
      tick(1);
      bus8.int_ack_i = 1'b0;
      checks++; if (bus8.int_o !== 1'b0 || bus8.int_vector !== 8'hFF) begin errors++; $display("FAIL idle_ack_ignored: got int_o %b vec %h want 0/ff", bus8.int_o, bus8.int_vector); end
      bus8.int_mask = 8'h01;
      tick(1);
      checks++; if (bus8.int_o !== 1'b1 || bus8.int_vector !== 8'h00) begin errors++; $display("FAIL unmask_reassert: got int_o %b vec %h want 1/00", bus8.int_o, bus8.int_vector); end
      $display("test_mask_drop done");
   endtask

   task automatic test_reset_32();
      apply_reset();
      bus32.int_mask = 32'h8000_0000; bus32.int_mode = 32'h8000_0000;
      bus32.int_src = 32'h8000_0000;
      tick(5);
      checks++; if (bus32.int_o !== 1'b1 || bus32.int_vector !== 8'd31) begin errors++; $display("FAIL r32_assert: got int_o %b vec %h want 1/1f", bus32.int_o, bus32.int_vector); end
      bus32.int_ack_i = 1'b1;
      tick(1);
      bus32.int_ack_i = 1'b0;
      checks++; if (bus32.int_o !== 1'b0 || bus32.int_vector !== 8'd31) begin errors++; $display("FAIL r32_service: got int_o %b vec %h want 0/1f", bus32.int_o, bus32.int_vector); end
      rst_i = 1'b1;
      tick(2);
      checks++; if (bus32.int_o !== 1'b0 || bus32.int_vector !== 8'hFF || bus32.interrupts !== 32'h0) begin errors++; $display("FAIL r32_in_reset: got int_o %b vec %h irq %h want 0/ff/0", bus32.int_o, bus32.int_vector, bus32.interrupts); end
      rst_i = 1'b0;
      tick(10);
      checks++; if (bus32.int_o !== 1'b0 || bus32.int_vector !== 8'hFF || bus32.interrupts !== 32'h0) begin errors++; $display("FAIL r32_no_edge: got int_o %b vec %h irq %h want 0/ff/0", bus32.int_o, bus32.int_vector, bus32.interrupts); end
      bus32.int_mode = 32'h0;
      rst_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
      tick(6);
      checks++; if (bus32.interrupts !== 32'h8000_0000) begin errors++; $display("FAIL r32_level_pend: got %h want 80000000", bus32.interrupts); end
      checks++; if (bus32.int_o !== 1'b1 || bus32.int_vector !== 8'd31) begin errors++; $display("FAIL r32_level_assert: got int_o %b vec %h want 1/1f", bus32.int_o, bus32.int_vector); end
      $display("test_reset_32 done");
   endtask

   initial begin
      test_reset();
      test_latency();
      test_priority_service();
      test_set_wins();
      test_level();
      test_mask_drop();
      test_reset_32();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
